// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 4-bit ALU and its command sequencer.
//   ALU_W          default datapath width
//   OP_*           3-bit opcode / ALU select encodings
//   seq_state_e    sequencer FSM states
//   op_uses_alu()  true for opcodes whose result comes from the ALU
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned ALU_W = 4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } seq_state_e;

  function automatic logic op_uses_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational W-bit ALU. All arithmetic is modulo 2^W with no carry out.
// Selects outside ADD/SUB/AND/OR/NOT produce 0, so an idle select (NOP)
// keeps the result quiet.
//   A      in  W  operand A
//   B      in  W  operand B (ignored by NOT)
//   sel    in  3  operation select (OP_* encodings)
//   result out W  operation result
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [2:0]   sel,
  output logic [W-1:0] result
);

  always_comb begin
    result = '0;
    case (sel)
      OP_ADD:  result = A + B;
      OP_SUB:  result = A - B;
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_NOT:  result = ~A;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
// Accepts ALU commands over valid/ready, runs each through an external
// combinational ALU using an internal accumulator as operand A, writes the
// result back to the accumulator and returns it over a valid/ready response
// channel. One command is in flight at a time (IDLE -> EXEC -> RESP).
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   cmd_valid   in   1      command present
//   cmd_ready   out  1      sequencer can accept a command
//   cmd_op      in   3      opcode (OP_* encodings)
//   cmd_opnd    in   W      operand B, or load value for LOAD
//   alu_a       out  W      to ALU A (accumulator during EXEC, else 0)
//   alu_b       out  W      to ALU B (latched operand during EXEC, else 0)
//   alu_sel     out  3      to ALU sel (latched opcode during EXEC, else NOP)
//   alu_result  in   W      from ALU result, same cycle
//   res_valid   out  1      response present
//   res_ready   in   1      response consumer ready
//   res_data    out  W      accumulator value after the command
//   res_zero    out  1      res_data == 0
//   op_count    out  CNT_W  completed responses, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned W     = ALU_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_opnd,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_sel,
  input  logic [W-1:0]     alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic             res_zero,
  output logic [CNT_W-1:0] op_count
);

  seq_state_e       state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [W-1:0]     res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accumulator value produced by the command currently in EXEC.
  logic [W-1:0]     acc_exec;

  always_comb begin
    acc_exec = acc_q;
    if (op_uses_alu(op_q)) begin
      acc_exec = alu_result;
    end else begin
      case (op_q)
        OP_LOAD: acc_exec = opnd_q;
        OP_CLR:  acc_exec = '0;
        default: acc_exec = acc_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    opnd_d      = opnd_q;
    cmd_ready_d = cmd_ready_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        // cmd_ready is a register, so the first cycle after reset release
        // is spent raising it; cmd_op is sampled only on an accepting edge
        // so an undriven opcode while cmd_valid is low never gets latched.
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          opnd_d      = cmd_opnd;
          cmd_ready_d = 1'b0;
          state_d     = EXEC;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      EXEC: begin
        acc_d       = acc_exec;
        res_data_d  = acc_exec;
        res_zero_d  = (acc_exec == '0);
        res_valid_d = 1'b1;
        state_d     = RESP;
      end

      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        cmd_ready_d = 1'b0;
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_q        <= OP_NOP;
      opnd_q      <= '0;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      cnt_q       <= cnt_d;
    end
  end

  // ALU ports are gated by the state register so the ALU sits on NOP with
  // zero operands whenever no command is executing.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = OP_NOP;
    if (state_q == EXEC) begin
      alu_a   = acc_q;
      alu_b   = opnd_q;
      alu_sel = op_q;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_opnd;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_zero;
  logic [7:0] op_count;

  alu_cmd_sequencer #(.W(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_opnd   (cmd_opnd),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_zero   (res_zero),
    .op_count   (op_count)
  );

  alu #(.W(4)) u_alu (
    .A      (alu_a),
    .B      (alu_b),
    .sel    (alu_sel),
    .result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       zero;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_accept = 0;
  int   n_hs     = 0;
  logic [7:0] exp_cnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input logic [3:0] d, input logic [7:0] c);
    exp_t e;
    e.data = d;
    e.zero = (d == 4'h0);
    e.cnt  = c;
    return e;
  endfunction

  // Monitor: tracks accepted commands to know which cycle is EXEC, checks
  // the ALU port gating, and pops the scoreboard on each response handshake.
  logic       exec_pend = 1'b0;
  logic [2:0] exec_op;
  logic [3:0] exec_opnd;

  always @(negedge clk) begin
    if (exec_pend) begin
      chk("exec_alu_sel", alu_sel, exec_op);
      chk("exec_alu_b", alu_b, exec_opnd);
    end else begin
      chk("idle_alu_sel", alu_sel, OP_NOP);
      chk("idle_alu_ab", {alu_a, alu_b}, 8'h00);
    end
    exec_pend = rst_n && cmd_valid && cmd_ready;
    if (exec_pend) begin
      exec_op   = cmd_op;
      exec_opnd = cmd_opnd;
      n_accept++;
    end
    if (res_valid && res_ready) begin
      n_hs++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got response %0h expected none", res_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_zero", res_zero, e.zero);
        chk("op_count_at_resp", op_count, e.cnt);
      end
    end
  end

  // All driver tasks start and end aligned to posedge + #1.
  task automatic wait_ready();
    int unsigned n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [3:0] opnd, input logic [3:0] exp);
    wait_ready();
    sb.push_back(mk_exp(exp, exp_cnt));
    exp_cnt = exp_cnt + 8'd1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_opnd  = opnd;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'bx;
    cmd_opnd  = 4'bx;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'bx;
    cmd_opnd  = 4'bx;
    res_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_zero", res_zero, 1);
    chk("rst_op_count", op_count, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_cmd_ready_low", cmd_ready, 0);
    @(posedge clk); #1;
    chk("rel_cmd_ready_high", cmd_ready, 1);

    // Basic load/add
    do_cmd(OP_LOAD, 4'h5, 4'h5);
    do_cmd(OP_ADD,  4'h3, 4'h8);
    wait_ready();
    chk("op_count_2", op_count, 2);

    // Wrap-around
    do_cmd(OP_LOAD, 4'h0, 4'h0);
    do_cmd(OP_SUB,  4'h1, 4'hF);
    do_cmd(OP_ADD,  4'h1, 4'h0);

    // Logic ops, CLEAR, NOP
    do_cmd(OP_LOAD, 4'hA, 4'hA);
    do_cmd(OP_AND,  4'h6, 4'h2);
    do_cmd(OP_OR,   4'h9, 4'hB);
    do_cmd(OP_NOT,  4'h5, 4'h4);
    do_cmd(OP_CLR,  4'h7, 4'h0);
    do_cmd(OP_NOP,  4'h3, 4'h0);
    wait_ready();
    chk("op_count_11", op_count, 11);

    // Backpressure with cmd_valid held high
    do_cmd(OP_LOAD, 4'h7, 4'h7);
    wait_ready();
    res_ready = 1'b0;
    sb.push_back(mk_exp(4'h8, exp_cnt));
    exp_cnt = exp_cnt + 8'd1;
    sb.push_back(mk_exp(4'h9, exp_cnt));
    exp_cnt = exp_cnt + 8'd1;
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_opnd  = 4'h1;
    @(posedge clk); #1;   // accepted, now EXEC
    @(posedge clk); #1;   // now RESP
    for (int i = 0; i < 5; i++) begin
      chk("stall_res_valid", res_valid, 1);
      chk("stall_res_data", res_data, 4'h8);
      chk("stall_cmd_ready", cmd_ready, 0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;   // handshake edge
    chk("post_hs_cmd_ready", cmd_ready, 1);
    chk("post_hs_res_valid", res_valid, 0);
    @(posedge clk); #1;   // second command accepted
    cmd_valid = 1'b0;
    cmd_op    = 3'bx;
    cmd_opnd  = 4'bx;
    wait_ready();
    chk("op_count_14", op_count, 14);
    chk("accepts_eq_handshakes", n_accept, n_hs);

    // Reset during EXEC of an ADD (acc = 9)
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_opnd  = 4'h2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'bx;
    cmd_opnd  = 4'bx;
    chk("exec_alu_a_acc", alu_a, 4'h9);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_sb_empty", sb.size(), 0);
    exp_cnt = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rel2_cmd_ready_low", cmd_ready, 0);
    @(posedge clk); #1;
    chk("rel2_cmd_ready_high", cmd_ready, 1);
    chk("rel2_op_count", op_count, 0);
    do_cmd(OP_NOP, 4'h6, 4'h0);   // acc must have been cleared by reset

    // op_count wrap: 256 completed NOPs in total since reset
    for (int i = 0; i < 255; i++) begin
      do_cmd(OP_NOP, 4'(i), 4'h0);
    end
    wait_ready();
    chk("op_count_wrap", op_count, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
